// File: rtl/im_arb_pkg.sv
// im_arb shared types: slot bundle, owner/state encodings, defaults.
package im_arb_pkg;

    localparam int AW_DEF         = 7;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOST
    } state_e;

    typedef enum logic {
        OWN_F,
        OWN_H
    } owner_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        owner_e      owner;
        logic        oor;
    } slot_t;

    function automatic logic out_of_range(
        input logic [31:0] a,
        input int          aw
    );
        return (a >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/im_arb_starve_ctr.sv
// Saturating count of fetch grants taken while the host waits.
module im_arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam logic [CW-1:0] MAXV = CW'(MAX);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAXV)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_max = (cnt == MAXV);

endmodule

// File: rtl/im_arb.sv
// Fetch/host arbiter for the instruction memory: one registered
// access slot per cycle, registered response two cycles after grant.
module im_arb
    import im_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic [31:0] f_rdata,
    output logic        f_valid,
    output logic        f_err,
    input  logic        h_req,
    input  logic        h_we,
    input  logic [31:0] h_addr,
    input  logic [31:0] h_wdata,
    output logic        h_gnt,
    output logic [31:0] h_rdata,
    output logic        h_valid,
    output logic        h_err,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    state_e      state;
    state_e      state_nx;
    slot_t       slot;
    slot_t       nslot;
    logic        fg;
    logic        hg;
    logic        at_max;
    logic        busy;
    logic        f_own;
    logic        h_own;
    logic [31:0] rd;

    im_arb_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fg && h_req),
        .clr   (hg || !h_req),
        .at_max(at_max)
    );

    always_comb begin
        fg       = 1'b0;
        hg       = 1'b0;
        state_nx = IDLE;
        nslot    = slot;
        if (h_req && (!f_req || at_max)) begin
            hg       = 1'b1;
            state_nx = HOST;
            nslot    = '{addr:  h_addr,
                         we:    h_we,
                         wdata: h_wdata,
                         owner: OWN_H,
                         oor:   out_of_range(h_addr, AW)};
        end else if (f_req) begin
            fg       = 1'b1;
            state_nx = FETCH;
            nslot    = '{addr:  f_addr,
                         we:    1'b0,
                         wdata: slot.wdata,
                         owner: OWN_F,
                         oor:   out_of_range(f_addr, AW)};
        end
    end

    // Grants are masked only at the ports; internal flops are held by reset.
    assign f_gnt = fg && rst_n;
    assign h_gnt = hg && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else begin
            slot <= nslot;
        end
    end

    assign busy    = (state != IDLE);
    assign f_own   = busy && (slot.owner == OWN_F);
    assign h_own   = busy && (slot.owner == OWN_H);
    assign m_addr  = slot.addr;
    assign m_wdata = slot.wdata;
    assign m_we    = h_own && slot.we && !slot.oor;
    assign rd      = slot.oor ? 32'd0 : m_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_valid <= 1'b0;
            f_rdata <= '0;
            f_err   <= 1'b0;
            h_valid <= 1'b0;
            h_rdata <= '0;
            h_err   <= 1'b0;
        end else begin
            f_valid <= f_own;
            h_valid <= h_own;
            if (f_own) begin
                f_rdata <= rd;
                f_err   <= slot.oor;
            end
            if (h_own) begin
                h_rdata <= rd;
                h_err   <= slot.oor;
            end
        end
    end

endmodule

// File: tb/tb_im_arb.sv
// Randomized bench for im_arb: instance 0 STARVE_MAX=4, instance 1
// STARVE_MAX=0, each checked against a transaction-level reference.
module tb_im_arb;

    logic clk = 1'b0;
    logic rst_n;
    logic load;
    always #5 clk = ~clk;

    logic [1:0]       f_req, f_gnt, f_valid, f_err;
    logic [1:0]       h_req, h_we, h_gnt, h_valid, h_err, m_we;
    logic [1:0][31:0] f_addr, f_rdata, h_addr, h_wdata, h_rdata;
    logic [1:0][31:0] m_addr, m_wdata, m_rdata;

    logic [31:0] mem0 [128];
    logic [31:0] mem1 [128];

    assign m_rdata[0] = mem0[m_addr[0][8:2]];
    assign m_rdata[1] = mem1[m_addr[1][8:2]];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 128; i++) begin
                mem0[i] <= 32'(i) + 32'h100;
                mem1[i] <= 32'(i) + 32'h100;
            end
        end else begin
            if (m_we[0]) mem0[m_addr[0][8:2]] <= m_wdata[0];
            if (m_we[1]) mem1[m_addr[1][8:2]] <= m_wdata[1];
        end
    end

    im_arb #(.AW(7), .STARVE_MAX(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req[0]), .f_addr(f_addr[0]), .f_gnt(f_gnt[0]),
        .f_rdata(f_rdata[0]), .f_valid(f_valid[0]), .f_err(f_err[0]),
        .h_req(h_req[0]), .h_we(h_we[0]), .h_addr(h_addr[0]),
        .h_wdata(h_wdata[0]), .h_gnt(h_gnt[0]), .h_rdata(h_rdata[0]),
        .h_valid(h_valid[0]), .h_err(h_err[0]),
        .m_addr(m_addr[0]), .m_we(m_we[0]), .m_wdata(m_wdata[0]),
        .m_rdata(m_rdata[0])
    );

    im_arb #(.AW(7), .STARVE_MAX(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req[1]), .f_addr(f_addr[1]), .f_gnt(f_gnt[1]),
        .f_rdata(f_rdata[1]), .f_valid(f_valid[1]), .f_err(f_err[1]),
        .h_req(h_req[1]), .h_we(h_we[1]), .h_addr(h_addr[1]),
        .h_wdata(h_wdata[1]), .h_gnt(h_gnt[1]), .h_rdata(h_rdata[1]),
        .h_valid(h_valid[1]), .h_err(h_err[1]),
        .m_addr(m_addr[1]), .m_we(m_we[1]), .m_wdata(m_wdata[1]),
        .m_rdata(m_rdata[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // requester intent
    bit          fp [2], hp [2], hwe [2];
    logic [31:0] fa [2], ha [2], hw [2], fseq [2];
    int          cnt [2];
    bit          gf [2], gh [2];
    // access accepted last cycle, response due this cycle
    bit          s1v [2], s1own [2], s1we [2];
    logic [31:0] s1a [2], s1d [2];
    bit          s2v [2], s2own [2], s2e [2];
    logic [31:0] s2d [2];
    logic [31:0] efr [2], ehr [2];
    bit          efe [2], ehe [2];
    logic [31:0] rmem [2][128];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit oor(input logic [31:0] a);
        return a[31:9] != 23'd0;
    endfunction

    function automatic logic [31:0] rand_in();
        logic [31:0] a;
        a = 32'($urandom_range(0, 127)) << 2;
        a[1:0] = 2'($urandom);
        return a;
    endfunction

    function automatic logic [31:0] rand_any();
        logic [31:0] a;
        a = rand_in();
        if ($urandom_range(0, 5) == 0)
            a[31:9] = 23'($urandom_range(1, 8388607));
        return a;
    endfunction

    function automatic int smax_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            fp[k] = 0; hp[k] = 0; cnt[k] = 0;
            s1v[k] = 0; s2v[k] = 0;
            efr[k] = '0; ehr[k] = '0; efe[k] = 0; ehe[k] = 0;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            f_req[k]   = fp[k];
            f_addr[k]  = fa[k];
            h_req[k]   = hp[k];
            h_we[k]    = hwe[k];
            h_addr[k]  = ha[k];
            h_wdata[k] = hw[k];
        end
    endtask

    // 0 fetch stream, 1 contention, 2 random, 3 no new, 4 host writes
    task automatic gen(input int mode);
        for (int k = 0; k < 2; k++) begin
            case (mode)
                0: if (!fp[k]) begin
                    fp[k] = 1; fa[k] = fseq[k];
                    fseq[k] = (fseq[k] + 32'd4) & 32'h1fc;
                end
                1: begin
                    if (!fp[k]) begin fp[k] = 1; fa[k] = rand_in(); end
                    if (!hp[k]) begin
                        hp[k] = 1; hwe[k] = 0; ha[k] = rand_in();
                    end
                end
                2: begin
                    if (!fp[k] && $urandom_range(0, 2) != 0) begin
                        fp[k] = 1; fa[k] = rand_any();
                    end
                    if (!hp[k] && $urandom_range(0, 1) != 0) begin
                        hp[k] = 1; hwe[k] = 1'($urandom);
                        ha[k] = rand_any(); hw[k] = $urandom;
                    end
                end
                4: if (!hp[k]) begin
                    hp[k] = 1; hwe[k] = 1; ha[k] = rand_in();
                    hw[k] = $urandom;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input int mode);
        bit starve;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            starve = cnt[k] >= smax_of(k);
            gf[k] = fp[k] && !(hp[k] && starve);
            gh[k] = hp[k] && (!fp[k] || starve);
            chk($sformatf("f_gnt%0d", k), 32'(f_gnt[k]), 32'(gf[k]));
            chk($sformatf("h_gnt%0d", k), 32'(h_gnt[k]), 32'(gh[k]));
            chk($sformatf("m_we%0d", k), 32'(m_we[k]),
                32'(s1v[k] && s1we[k] && !oor(s1a[k])));
            if (s1v[k])
                chk($sformatf("m_addr%0d", k), m_addr[k], s1a[k]);
            if (s1v[k] && s1we[k])
                chk($sformatf("m_wdata%0d", k), m_wdata[k], s1d[k]);
            if (s2v[k] && !s2own[k]) begin efr[k] = s2d[k]; efe[k] = s2e[k]; end
            if (s2v[k] && s2own[k])  begin ehr[k] = s2d[k]; ehe[k] = s2e[k]; end
            chk($sformatf("f_valid%0d", k), 32'(f_valid[k]),
                32'(s2v[k] && !s2own[k]));
            chk($sformatf("h_valid%0d", k), 32'(h_valid[k]),
                32'(s2v[k] && s2own[k]));
            chk($sformatf("f_rdata%0d", k), f_rdata[k], efr[k]);
            chk($sformatf("f_err%0d", k), 32'(f_err[k]), 32'(efe[k]));
            chk($sformatf("h_rdata%0d", k), h_rdata[k], ehr[k]);
            chk($sformatf("h_err%0d", k), 32'(h_err[k]), 32'(ehe[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (s1v[k]) begin
                s2e[k] = oor(s1a[k]);
                s2d[k] = s2e[k] ? 32'd0 : rmem[k][s1a[k][8:2]];
                if (s1we[k] && !s2e[k]) rmem[k][s1a[k][8:2]] = s1d[k];
            end
            s2v[k] = s1v[k];
            s2own[k] = s1own[k];
            s1v[k] = gf[k] || gh[k];
            if (gf[k]) begin s1a[k] = fa[k]; s1we[k] = 0; s1own[k] = 0; end
            if (gh[k]) begin
                s1a[k] = ha[k]; s1we[k] = hwe[k]; s1d[k] = hw[k]; s1own[k] = 1;
            end
            if (gh[k] || !hp[k]) cnt[k] = 0;
            else if (gf[k] && cnt[k] < smax_of(k)) cnt[k]++;
            if (gf[k]) fp[k] = 0;
            if (gh[k]) hp[k] = 0;
        end
        #1;
        gen(mode);
        drive();
    endtask

    task automatic chk_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_f_gnt%0d", k), 32'(f_gnt[k]), 32'd0);
            chk($sformatf("rst_h_gnt%0d", k), 32'(h_gnt[k]), 32'd0);
            chk($sformatf("rst_f_valid%0d", k), 32'(f_valid[k]), 32'd0);
            chk($sformatf("rst_h_valid%0d", k), 32'(h_valid[k]), 32'd0);
            chk($sformatf("rst_f_rdata%0d", k), f_rdata[k], 32'd0);
            chk($sformatf("rst_h_rdata%0d", k), h_rdata[k], 32'd0);
            chk($sformatf("rst_f_err%0d", k), 32'(f_err[k]), 32'd0);
            chk($sformatf("rst_h_err%0d", k), 32'(h_err[k]), 32'd0);
            chk($sformatf("rst_m_we%0d", k), 32'(m_we[k]), 32'd0);
            chk($sformatf("rst_m_addr%0d", k), m_addr[k], 32'd0);
            chk($sformatf("rst_m_wdata%0d", k), m_wdata[k], 32'd0);
        end
    endtask

    initial begin
        logic [6:0]  idx;
        logic [31:0] old;
        rst_n = 1'b0;
        load  = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            fseq[k] = '0; fa[k] = '0; ha[k] = '0; hw[k] = '0; hwe[k] = 0;
            for (int i = 0; i < 128; i++) rmem[k][i] = 32'(i) + 32'h100;
            fp[k] = 1; hp[k] = 1;
        end
        drive();
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        chk_reset();
        model_reset();
        drive();
        @(posedge clk); #1;
        rst_n = 1'b1;

        repeat (20) step(0);
        repeat (30) step(1);
        repeat (4) step(3);

        for (int k = 0; k < 2; k++) begin
            hp[k] = 1; hwe[k] = 1; ha[k] = 32'h10; hw[k] = 32'hdeadbeef;
        end
        drive();
        step(3);
        for (int k = 0; k < 2; k++) begin fp[k] = 1; fa[k] = 32'h10; end
        drive();
        repeat (4) step(3);
        chk("wr_then_fetch", f_rdata[0], 32'hdeadbeef);

        for (int k = 0; k < 2; k++) begin
            hp[k] = 1; hwe[k] = 1; ha[k] = 32'h200; hw[k] = 32'h12345678;
        end
        drive();
        repeat (4) step(3);
        chk("oor_err", 32'(h_err[0]), 32'd1);
        chk("oor_rdata", h_rdata[0], 32'd0);
        chk("oor_mem", mem0[0], 32'h100);

        repeat (300) step(2);

        repeat (4) step(3);
        for (int t = 0; t < 8 && !(s1v[0] && s1we[0]); t++) step(4);
        chk("rst_slot_busy", 32'(s1v[0] && s1we[0]), 32'd1);
        idx = s1a[0][8:2];
        old = rmem[0][idx];
        #2 rst_n = 1'b0;
        #1 chk_reset();
        model_reset();
        drive();
        @(posedge clk); #1;
        chk("rst_no_write", mem0[idx], old);
        rst_n = 1'b1;

        repeat (60) step(2);
        repeat (4) step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/im_arb.md
# im_arb

Two-port arbiter and access sequencer for the 128-word instruction memory. It shares the single memory port between the CPU fetch path and a host program-loader/debug port, and guarantees the host bounded access while fetch is streaming. Every access is registered into a fixed one-cycle memory slot, and the read data is returned registered with a valid pulse. The block sits between the fetch stage, the loader, and the instruction memory, whose read path is combinational.

## Interface
- `AW`, 7: word-address bits; the memory depth is 2^AW words.
- `STARVE_MAX`, 4: maximum consecutive fetch grants while the host waits. 0 gives the host strict priority.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `f_req` in 1: fetch request.
- `f_addr` in 32: fetch byte address.
- `f_gnt` out 1: fetch request accepted this cycle.
- `f_rdata` out 32: fetch read data.
- `f_valid` out 1: one-cycle pulse; `f_rdata`/`f_err` are valid.
- `f_err` out 1: the fetch address was out of range.
- `h_req` in 1: host request.
- `h_we` in 1: host write (1) or read (0).
- `h_addr` in 32: host byte address.
- `h_wdata` in 32: host write data.
- `h_gnt` out 1: host request accepted this cycle.
- `h_rdata` out 32: host read data.
- `h_valid` out 1: one-cycle pulse; completes a host read or acknowledges a host write.
- `h_err` out 1: the host address was out of range.
- `m_addr` out 32: memory address.
- `m_we` out 1: memory write enable.
- `m_wdata` out 32: memory write data.
- `m_rdata` in 32: memory read data (combinational from `m_addr`).

## Operation
- States: IDLE (no access in the slot), FETCH (fetch owns the slot), HOST (host owns the slot). The next state equals the grant decided this cycle.
- Grant rules (combinational, at most one grant per cycle):
  - Only `f_req` high → `f_gnt`.
  - Only `h_req` high → `h_gnt`.
  - Both high → `f_gnt`, unless the starve count has reached `STARVE_MAX`; then `h_gnt`.
- Starve count:
  - Increments on each `f_gnt` while `h_req` is high, saturating at `STARVE_MAX`.
  - Clears on `h_gnt`, and clears whenever `h_req` is low.
- An accepted request latches its address, `we`, wdata and owner into the slot registers.
- `m_addr`, `m_we` and `m_wdata` are driven only from the slot registers. In IDLE: `m_we`=0, and `m_addr`/`m_wdata` hold their last values.
- Range check: the access is out of range if `addr[31:AW+2]` ≠ 0.
  - Out-of-range accesses are still granted, but `m_we` is forced to 0 for that slot.
  - The response carries err=1 and rdata=0.
- `addr[1:0]` are ignored; no alignment error is raised.
- Response data:
  - At the end of the slot cycle, `m_rdata` is captured into the owner's rdata register.
  - The owner's valid pulses the next cycle.
  - The non-owner's valid stays 0 and its rdata holds.
- Host writes: `h_valid` pulses as an acknowledgement; `h_rdata` is updated with `m_rdata` from the written address, which is the old contents.
- Requesters keep req/addr/we/wdata stable until they are granted.

## Timing
- Reset values: `f_gnt`=`h_gnt`=0 while `rst_n` is low; `f_valid`=`h_valid`=0, `f_err`=`h_err`=0, `f_rdata`=`h_rdata`=0, `m_addr`=0, `m_we`=0, `m_wdata`=0, state IDLE, starve count 0.
- Latency:
  - Request granted in cycle N → memory slot in cycle N+1 → valid in cycle N+2.
  - Fixed at 2 cycles from grant to valid.
- Throughput: one access per cycle, fully pipelined; back-to-back grants are allowed every cycle.
- Writes: the memory write occurs on the rising edge that ends slot cycle N+1.
- Reset mid-operation: an asynchronous assert immediately clears the slot, `m_we` and any pending valid. The in-flight response is dropped, and no write occurs after `rst_n` falls.
- Simultaneous requests with count=`STARVE_MAX`: the host wins, and the count clears on the next edge.

## Structure
- Package `im_arb_pkg` holds:
  - the state enum `{IDLE, FETCH, HOST}`;
  - the owner encoding;
  - a slot struct `{addr, we, wdata, owner, oor}`;
  - the default `AW`/`STARVE_MAX` constants.
- Sub-module `im_arb_starve_ctr`: a saturating counter with inc/clr inputs and an `at_max` output.
- The grant logic, slot registers and response registers stay in `im_arb`.

## Test plan
- Fetch-only stream: `f_req` held high with `f_addr`=0,4,8,… while memory contains i+0x100 → `f_gnt` every cycle; `f_valid` every cycle from cycle 2; `f_rdata`=0x100,0x101,….
- Contention: `f_req` and `h_req` both held high, `STARVE_MAX`=4 → grant pattern F,F,F,F,H repeating; `h_valid` two cycles after each `h_gnt`.
- Host write then fetch: host writes 0xDEADBEEF to 0x10, then fetch reads 0x10 → `h_valid` pulse; then `f_rdata`=0xDEADBEEF.
- Out of range: host write to 0x200 with `AW`=7 → `h_err`=1, `h_rdata`=0, `m_we` never asserted, memory unchanged.
- Reset mid-access: `rst_n` dropped during the slot cycle of a host write → `m_we` falls immediately; no `h_valid`; all outputs at reset values.
- `STARVE_MAX`=0: both requesters active → host granted every cycle; fetch granted only when `h_req` is low.
